// File: rtl/regfile_dump_64.sv
// Debug dump engine: walks a register-file index range (with wrap-around) through one
// combinational read port and streams each value out on a valid/ready interface.
module regfile_dump_64 #(
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 5,
  parameter int ZERO_X0 = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_reg,
  input  logic [ADDR_W-1:0] last_reg,
  input  logic              abort,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_idx,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, READ, HOLD, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] last;

  // x0 is hardwired zero in the integer file, so report it that way regardless of rd_data
  function automatic logic [DATA_W-1:0] capture_word(input logic [ADDR_W-1:0] a,
                                                     input logic [DATA_W-1:0] d);
    if (ZERO_X0 != 0 && a == '0) return '0;
    return d;
  endfunction

  assign rd_addr = idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      last      <= '0;
      out_data  <= '0;
      out_idx   <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            idx   <= first_reg;
            last  <= last_reg;
            busy  <= 1'b1;
            state <= READ;
          end
        end
        READ: begin
          if (abort) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            out_data  <= capture_word(idx, rd_data);
            out_idx   <= idx;
            out_valid <= 1'b1;
            state     <= HOLD;
          end
        end
        HOLD: begin
          // abort wins over a same-cycle handshake: the pending word is dropped
          if (abort) begin
            out_valid <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            if (idx == last) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              idx   <= idx + 1'b1;
              state <= READ;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_64.sv
// Bench for regfile_dump_64: randomized register contents and handshakes checked against
// a range/word-list reference model of the dump.
module tb_regfile_dump_64;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        out_ready = 1'b0;
  logic [4:0]  first_reg = '0;
  logic [4:0]  last_reg = '0;
  logic [4:0]  rd_addr;
  logic [4:0]  out_idx;
  logic [63:0] rd_data;
  logic [63:0] out_data;
  logic        out_valid, busy, done;

  logic [63:0] regs [32];
  assign rd_data = regs[rd_addr];

  regfile_dump_64 #(.DATA_W(64), .ADDR_W(5), .ZERO_X0(1)) dut (
    .clk(clk), .reset(reset), .start(start), .first_reg(first_reg), .last_reg(last_reg),
    .abort(abort), .rd_addr(rd_addr), .rd_data(rd_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // reference model: expected word list for a range
  int          exp_idx[$];
  logic [63:0] exp_data[$];

  function automatic void build_exp(input int f, input int l);
    int n;
    exp_idx.delete();
    exp_data.delete();
    n = (((l - f) % 32) + 32) % 32 + 1;
    for (int k = 0; k < n; k++) begin
      exp_idx.push_back((f + k) % 32);
      exp_data.push_back(((f + k) % 32 == 0) ? 64'h0 : regs[(f + k) % 32]);
    end
  endfunction

  // results collected by the dump driver
  int          got_idx[$];
  logic [63:0] got_data[$];
  int          hs_cyc[$];
  int          done_cnt, done_cyc, start_cyc, first_valid_cyc, abort_cyc, unstable, timed_out;
  logic        valid_at_done, busy_at_done, busy_after, done_after;

  // mode 0: ready always; 1: low 5 cycles then toggling; 2: random
  task automatic run_dump(input int f, input int l, input int mode, input int abort_word,
                          input bit spurious);
    logic        held, hs;
    logic [63:0] hd;
    logic [4:0]  hi;
    int          k;
    got_idx.delete(); got_data.delete(); hs_cyc.delete();
    done_cnt = 0; unstable = 0; timed_out = 0; first_valid_cyc = -1; abort_cyc = -1;
    held = 1'b0; hd = '0; hi = '0;
    @(negedge clk);
    start = 1'b1; first_reg = 5'(f); last_reg = 5'(l); start_cyc = cyc;
    @(negedge clk);
    start = 1'b0; first_reg = 5'($urandom); last_reg = 5'($urandom);
    k = 0;
    while (done_cnt == 0) begin
      if (k > 600) begin
        timed_out = 1;
        break;
      end
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (k < 5) ? 1'b0 : k[0];
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      abort = 1'b0;
      if (abort_word >= 0 && out_valid && got_idx.size() == abort_word) begin
        abort = 1'b1; out_ready = 1'b1; abort_cyc = cyc;
      end
      if (spurious && k == 3) begin
        start = 1'b1; first_reg = 5'd20; last_reg = 5'd25;
      end else start = 1'b0;
      if (done) begin
        done_cnt++; done_cyc = cyc; valid_at_done = out_valid; busy_at_done = busy;
      end
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (out_valid && held && (out_data !== hd || out_idx !== hi)) unstable++;
      hs = out_valid && out_ready && !abort;
      if (hs) begin
        got_idx.push_back(int'(out_idx)); got_data.push_back(out_data); hs_cyc.push_back(cyc);
      end
      held = out_valid && !hs; hd = out_data; hi = out_idx;
      @(negedge clk);
      k++;
    end
    abort = 1'b0; start = 1'b0; out_ready = 1'b0;
    busy_after = busy; done_after = done;
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl: valid/busy/done=%b%b%b want 000", out_valid, busy, done);
    end
    checks++; if (out_idx !== 5'd0 || out_data !== 64'd0 || rd_addr !== 5'd0) begin
      errors++; $display("FAIL reset_data: idx=%0d data=%h rd_addr=%0d want 0", out_idx, out_data, rd_addr);
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset: busy=%b valid=%b want 0 0", busy, out_valid);
    end
  endtask

  task automatic test_full_dump();
    for (int i = 0; i < 32; i++) regs[i] = 64'h1000 + 64'(i);
    run_dump(0, 31, 0, -1, 1'b0);
    build_exp(0, 31);
    checks++; if (timed_out != 0) begin errors++; $display("FAIL full_timeout: got %0d want 0", timed_out); end
    checks++; if (got_idx.size() != 32) begin errors++; $display("FAIL full_count: got %0d want 32", got_idx.size()); end
    for (int j = 0; j < exp_idx.size() && j < got_idx.size(); j++) begin
      checks++; if (got_idx[j] != exp_idx[j] || got_data[j] !== exp_data[j]) begin
        errors++; $display("FAIL full_word%0d: got idx %0d data %h want idx %0d data %h",
                           j, got_idx[j], got_data[j], exp_idx[j], exp_data[j]);
      end
      if (j > 0) begin
        checks++; if (hs_cyc[j] - hs_cyc[j-1] != 2) begin
          errors++; $display("FAIL full_spacing%0d: got %0d want 2", j, hs_cyc[j] - hs_cyc[j-1]);
        end
      end
    end
    checks++; if (first_valid_cyc - start_cyc != 2) begin
      errors++; $display("FAIL full_latency: got %0d want 2", first_valid_cyc - start_cyc);
    end
    checks++; if (done_cnt != 1 || hs_cyc.size() == 0 || done_cyc != hs_cyc[hs_cyc.size()-1] + 1) begin
      errors++; $display("FAIL full_done: cnt %0d cyc %0d want cnt 1 one cycle after last word", done_cnt, done_cyc);
    end
    checks++; if (busy_at_done !== 1'b1 || busy_after !== 1'b0 || done_after !== 1'b0) begin
      errors++; $display("FAIL full_busy: at_done %b after %b done_after %b want 1 0 0",
                         busy_at_done, busy_after, done_after);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 32; i++) regs[i] = {$urandom, $urandom};
    run_dump(30, 1, 2, -1, 1'b0);
    build_exp(30, 1);
    checks++; if (timed_out != 0 || got_idx.size() != 4) begin
      errors++; $display("FAIL wrap_count: got %0d (timeout %0d) want 4", got_idx.size(), timed_out);
    end
    for (int j = 0; j < exp_idx.size() && j < got_idx.size(); j++) begin
      checks++; if (got_idx[j] != exp_idx[j] || got_data[j] !== exp_data[j]) begin
        errors++; $display("FAIL wrap_word%0d: got idx %0d data %h want idx %0d data %h",
                           j, got_idx[j], got_data[j], exp_idx[j], exp_data[j]);
      end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL wrap_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_single();
    regs[7] = 64'hDEAD_BEEF_0000_0007;
    run_dump(7, 7, 0, -1, 1'b0);
    checks++; if (got_idx.size() != 1 || got_idx[0] != 7 || got_data[0] !== 64'hDEAD_BEEF_0000_0007) begin
      errors++; $display("FAIL single_word: got %0d words first idx %0d want 1 word idx 7 data deadbeef00000007",
                         got_idx.size(), (got_idx.size() > 0) ? got_idx[0] : -1);
    end
    checks++; if (done_cnt != 1 || hs_cyc.size() != 1 || done_cyc != hs_cyc[0] + 1) begin
      errors++; $display("FAIL single_done: cnt %0d cyc %0d want 1 pulse right after handshake", done_cnt, done_cyc);
    end
  endtask

  task automatic test_backpressure();
    int f;
    for (int i = 0; i < 32; i++) regs[i] = {$urandom, $urandom};
    f = $urandom_range(0, 31);
    run_dump(f, (f + 4) % 32, 1, -1, 1'b0);
    build_exp(f, (f + 4) % 32);
    checks++; if (timed_out != 0 || got_idx.size() != 5) begin
      errors++; $display("FAIL bp_count: got %0d (timeout %0d) want 5", got_idx.size(), timed_out);
    end
    checks++; if (unstable != 0) begin errors++; $display("FAIL bp_stable: got %0d changes want 0", unstable); end
    for (int j = 0; j < exp_idx.size() && j < got_idx.size(); j++) begin
      checks++; if (got_idx[j] != exp_idx[j] || got_data[j] !== exp_data[j]) begin
        errors++; $display("FAIL bp_word%0d: got idx %0d data %h want idx %0d data %h",
                           j, got_idx[j], got_data[j], exp_idx[j], exp_data[j]);
      end
    end
  endtask

  task automatic test_abort();
    int f;
    f = $urandom_range(0, 31);
    run_dump(f, (f + 9) % 32, 0, 2, 1'b0);
    checks++; if (got_idx.size() != 2) begin errors++; $display("FAIL abort_count: got %0d want 2", got_idx.size()); end
    checks++; if (done_cnt != 1 || abort_cyc < 0 || done_cyc != abort_cyc + 1 || valid_at_done !== 1'b0) begin
      errors++; $display("FAIL abort_done: cnt %0d done_cyc %0d abort_cyc %0d valid %b want done next cycle valid 0",
                         done_cnt, done_cyc, abort_cyc, valid_at_done);
    end
    f = $urandom_range(0, 31);
    run_dump(f, (f + 2) % 32, 2, -1, 1'b0);
    build_exp(f, (f + 2) % 32);
    checks++; if (got_idx.size() != 3) begin errors++; $display("FAIL after_abort_count: got %0d want 3", got_idx.size()); end
    for (int j = 0; j < exp_idx.size() && j < got_idx.size(); j++) begin
      checks++; if (got_idx[j] != exp_idx[j] || got_data[j] !== exp_data[j]) begin
        errors++; $display("FAIL after_abort_word%0d: got idx %0d data %h want idx %0d data %h",
                           j, got_idx[j], got_data[j], exp_idx[j], exp_data[j]);
      end
    end
  endtask

  task automatic test_reset_mid_dump();
    int dones;
    for (int i = 0; i < 32; i++) regs[i] = {$urandom, $urandom};
    @(negedge clk);
    start = 1'b1; first_reg = 5'd0; last_reg = 5'd31; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_hold: valid %b want 1", out_valid); end
    #2 reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL async_reset: valid/busy/done=%b%b%b want 000", out_valid, busy, done);
    end
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) dones++;
    end
    checks++; if (dones != 0) begin errors++; $display("FAIL reset_no_done: got %0d pulses want 0", dones); end
    run_dump(0, 3, 0, -1, 1'b1);
    build_exp(0, 3);
    checks++; if (timed_out != 0 || got_idx.size() != 4) begin
      errors++; $display("FAIL post_reset_count: got %0d (timeout %0d) want 4", got_idx.size(), timed_out);
    end
    for (int j = 0; j < exp_idx.size() && j < got_idx.size(); j++) begin
      checks++; if (got_idx[j] != exp_idx[j] || got_data[j] !== exp_data[j]) begin
        errors++; $display("FAIL post_reset_word%0d: got idx %0d data %h want idx %0d data %h",
                           j, got_idx[j], got_data[j], exp_idx[j], exp_data[j]);
      end
    end
    repeat (20) @(negedge clk);
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL busy_start_ignored: busy %b valid %b want 0 0", busy, out_valid);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = '0;
    test_reset();
    test_full_dump();
    test_wrap();
    test_single();
    test_backpressure();
    test_abort();
    test_reset_mid_dump();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
